// File: rtl/prog_host.sv
// Program host: loads a program image into data memory, pulses the core request,
// waits for the core to finish (with a run timeout), then streams results out.
module prog_host #(
    parameter int unsigned LOAD_BASE  = 0,
    parameter int unsigned LOAD_LEN   = 64,
    parameter int unsigned RES_BASE   = 64,
    parameter int unsigned RES_LEN    = 64,
    parameter int unsigned REQ_CYCLES = 2,
    parameter int unsigned TIMEOUT    = 4095
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       load_valid,
    input  logic [7:0] load_data,
    output logic       load_ready,
    output logic       mem_wr_en,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wr_data,
    input  logic [7:0] mem_rd_data,
    output logic       core_req,
    input  logic       core_done,
    output logic       out_valid,
    output logic [7:0] out_data,
    input  logic       out_ready,
    output logic       busy,
    output logic       timeout_err
);

    localparam int unsigned CNT_W   = 16;
    localparam int unsigned ADDR_W  = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        REQ   = 3'd2,
        RUN   = 3'd3,
        DRAIN = 3'd4,
        ERR   = 3'd5
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic               err;

    // One shared counter: byte index in LOAD/DRAIN, request cycles in REQ, run cycles in RUN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD;
                        count <= '0;
                        err   <= 1'b0;
                    end
                end
                LOAD: begin
                    if (load_valid) begin
                        if (count == CNT_W'(LOAD_LEN - 1)) begin
                            state <= REQ;
                            count <= '0;
                        end else begin
                            count <= count + CNT_W'(1);
                        end
                    end
                end
                REQ: begin
                    if (count == CNT_W'(REQ_CYCLES - 1)) begin
                        state <= RUN;
                        count <= '0;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                RUN: begin
                    // core_done wins over a timeout landing in the same cycle
                    if (core_done) begin
                        state <= DRAIN;
                        count <= '0;
                    end else if (count == CNT_W'(TIMEOUT - 1)) begin
                        state <= ERR;
                        count <= '0;
                        err   <= 1'b1;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (count == CNT_W'(RES_LEN - 1)) begin
                            state <= IDLE;
                            count <= '0;
                        end else begin
                            count <= count + CNT_W'(1);
                        end
                    end
                end
                ERR: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase
        end
    end

    // Handshake outputs decode from state so they react in the same cycle as the inputs.
    always_comb begin
        load_ready  = 1'b0;
        mem_wr_en   = 1'b0;
        mem_addr    = '0;
        mem_wr_data = '0;
        core_req    = 1'b0;
        out_valid   = 1'b0;
        out_data    = '0;
        case (state)
            LOAD: begin
                load_ready  = 1'b1;
                mem_wr_en   = load_valid;
                mem_addr    = ADDR_W'(LOAD_BASE) + count[ADDR_W-1:0];
                mem_wr_data = load_data;
            end
            REQ: begin
                core_req = 1'b1;
            end
            DRAIN: begin
                mem_addr  = ADDR_W'(RES_BASE) + count[ADDR_W-1:0];
                out_valid = 1'b1;
                out_data  = mem_rd_data;
            end
            default: begin
            end
        endcase
    end

    assign busy        = (state != IDLE);
    assign timeout_err = err;

endmodule

// File: tb/tb_prog_host.sv
// Bench for prog_host: random load/drain sessions checked against a byte-level session model.
module tb_prog_host;

    localparam int unsigned LOAD_BASE  = 0;
    localparam int unsigned LOAD_LEN   = 64;
    localparam int unsigned RES_BASE   = 64;
    localparam int unsigned RES_LEN    = 64;
    localparam int unsigned REQ_CYCLES = 2;
    localparam int unsigned TIMEOUT    = 20;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       load_valid;
    logic [7:0] load_data;
    logic       load_ready;
    logic       mem_wr_en;
    logic [7:0] mem_addr;
    logic [7:0] mem_wr_data;
    logic [7:0] mem_rd_data;
    logic       core_req;
    logic       core_done;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       busy;
    logic       timeout_err;

    int total = 0;
    int bad   = 0;

    logic [7:0] load_mem [256];
    logic [7:0] res_mem  [256];
    int         wr_total = 0;

    prog_host #(
        .LOAD_BASE (LOAD_BASE),
        .LOAD_LEN  (LOAD_LEN),
        .RES_BASE  (RES_BASE),
        .RES_LEN   (RES_LEN),
        .REQ_CYCLES(REQ_CYCLES),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .mem_wr_en  (mem_wr_en),
        .mem_addr   (mem_addr),
        .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data),
        .core_req   (core_req),
        .core_done  (core_done),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Load writes land in load_mem; results are read from a separately preloaded image.
    always @(posedge clk) begin
        if (mem_wr_en) begin
            load_mem[mem_addr] <= mem_wr_data;
            wr_total           <= wr_total + 1;
        end
    end
    assign mem_rd_data = res_mem[mem_addr];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic preload_results(input bit ramp);
        for (int a = 0; a < 256; a++)
            res_mem[a] = ramp ? 8'(a) : 8'($urandom);
    endtask

    task automatic do_load(input int mode);
        logic [7:0] bytes [LOAD_LEN];
        int  idx = 0;
        int  cyc = 0;
        int  w0  = wr_total;
        int  errs = 0;
        bit  v;
        while (idx < int'(LOAD_LEN) && cyc < 1000) begin
            v = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : ($urandom_range(0, 2) != 0);
            bytes[idx] = (mode == 0) ? 8'(idx) : 8'($urandom);
            load_valid = v;
            load_data  = v ? bytes[idx] : 8'($urandom);
            @(negedge clk);
            total++;
            if (load_ready !== 1'b1) begin
                bad++;
                $display("FAIL load_ready byte %0d: got %b want 1", idx, load_ready);
            end
            total++;
            if (mem_wr_en !== v) begin
                bad++;
                $display("FAIL load_wr_en byte %0d: got %b want %b", idx, mem_wr_en, v);
            end
            if (v) begin
                total++;
                if (mem_addr !== 8'(LOAD_BASE + idx) || mem_wr_data !== bytes[idx]) begin
                    bad++;
                    $display("FAIL load_write byte %0d: got addr %0h data %0h want addr %0h data %0h",
                             idx, mem_addr, mem_wr_data, 8'(LOAD_BASE + idx), bytes[idx]);
                end
            end
            tick();
            if (v) idx++;
            cyc++;
        end
        load_valid = 1'b0;
        total++;
        if (idx != int'(LOAD_LEN)) begin
            bad++;
            $display("FAIL load_budget: got %0d bytes want %0d", idx, LOAD_LEN);
        end
        for (int i = 0; i < idx; i++)
            if (load_mem[8'(LOAD_BASE + i)] !== bytes[i]) errs++;
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL load_image: got %0d wrong bytes want 0", errs);
        end
        total++;
        if (wr_total - w0 != int'(LOAD_LEN)) begin
            bad++;
            $display("FAIL load_write_count: got %0d want %0d", wr_total - w0, LOAD_LEN);
        end
    endtask

    task automatic do_req(input bit done_in_req);
        int n = 0;
        while (n < 40) begin
            if (core_req !== 1'b1) break;
            core_done = done_in_req;
            n++;
            tick();
        end
        core_done = 1'b0;
        total++;
        if (n != int'(REQ_CYCLES)) begin
            bad++;
            $display("FAIL req_cycles: got %0d want %0d", n, REQ_CYCLES);
        end
    endtask

    task automatic do_run(input int done_at, input bit poke_start);
        for (int r = 0; r <= done_at; r++) begin
            total++;
            if (busy !== 1'b1 || out_valid !== 1'b0 || core_req !== 1'b0 || load_ready !== 1'b0) begin
                bad++;
                $display("FAIL run_cycle %0d: got busy %b out_valid %b core_req %b load_ready %b want 1 0 0 0",
                         r, busy, out_valid, core_req, load_ready);
            end
            core_done = (r == done_at);
            start     = poke_start && (r == 2);
            tick();
            start = 1'b0;
        end
        core_done = 1'b0;
        total++;
        if (out_valid !== 1'b1 || timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL run_to_drain: got out_valid %b timeout_err %b want 1 0", out_valid, timeout_err);
        end
    endtask

    task automatic do_drain(input int mode);
        int stall;
        logic [7:0] exp;
        for (int i = 0; i < int'(RES_LEN); i++) begin
            stall = (mode == 0) ? 0 : (mode == 1) ? 3 : $urandom_range(0, 3);
            exp   = res_mem[8'(RES_BASE + i)];
            for (int s = 0; s <= stall; s++) begin
                out_ready = (s == stall);
                @(negedge clk);
                total++;
                if (out_valid !== 1'b1 || out_data !== exp || mem_addr !== 8'(RES_BASE + i) || mem_wr_en !== 1'b0) begin
                    bad++;
                    $display("FAIL drain byte %0d: got valid %b data %0h addr %0h wr %b want 1 %0h %0h 0",
                             i, out_valid, out_data, mem_addr, mem_wr_en, exp, 8'(RES_BASE + i));
                end
                tick();
            end
        end
        out_ready = 1'b0;
        total++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL drain_end: got busy %b out_valid %b want 0 0", busy, out_valid);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b0; load_valid = 1'b0; load_data = 8'h00;
        core_done = 1'b0; out_ready = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || load_ready !== 1'b0 || mem_wr_en !== 1'b0 || core_req !== 1'b0 ||
            out_valid !== 1'b0 || timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags: got busy %b lr %b wr %b req %b ov %b err %b want all 0",
                     busy, load_ready, mem_wr_en, core_req, out_valid, timeout_err);
        end
        total++;
        if (mem_addr !== 8'h00 || mem_wr_data !== 8'h00 || out_data !== 8'h00) begin
            bad++;
            $display("FAIL reset_data: got addr %0h wdata %0h odata %0h want 0 0 0", mem_addr, mem_wr_data, out_data);
        end
        repeat (2) tick();
        reset = 1'b0;
        tick();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: got busy %b want 0", busy);
        end
    endtask

    task automatic test_back_to_back;
        preload_results(1'b1);
        pulse_start();
        total++;
        if (busy !== 1'b1 || load_ready !== 1'b1) begin
            bad++;
            $display("FAIL start_to_load: got busy %b load_ready %b want 1 1", busy, load_ready);
        end
        do_load(0);
        do_req(1'b0);
        do_run(5, 1'b0);
        do_drain(0);
    endtask

    task automatic test_load_gaps;
        preload_results(1'b0);
        pulse_start();
        do_load(1);
        do_req(1'b0);
        do_run(3, 1'b0);
        do_drain(2);
    endtask

    task automatic test_done_in_req;
        preload_results(1'b1);
        pulse_start();
        do_load(2);
        do_req(1'b1);
        do_run(10, 1'b1);
        do_drain(1);
    endtask

    task automatic test_timeout;
        int n = 0;
        preload_results(1'b0);
        pulse_start();
        do_load(2);
        do_req(1'b0);
        while (busy === 1'b1 && timeout_err === 1'b0 && n < 100) begin
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL timeout_run %0d: got out_valid %b want 0", n, out_valid);
            end
            core_done = 1'b0;
            n++;
            tick();
        end
        total++;
        if (n != int'(TIMEOUT)) begin
            bad++;
            $display("FAIL timeout_cycles: got %0d want %0d", n, TIMEOUT);
        end
        total++;
        if (busy !== 1'b1 || timeout_err !== 1'b1) begin
            bad++;
            $display("FAIL timeout_err_state: got busy %b err %b want 1 1", busy, timeout_err);
        end
        tick();
        total++;
        if (busy !== 1'b0 || timeout_err !== 1'b1) begin
            bad++;
            $display("FAIL timeout_idle: got busy %b err %b want 0 1", busy, timeout_err);
        end
        repeat (3) tick();
        total++;
        if (timeout_err !== 1'b1) begin
            bad++;
            $display("FAIL timeout_sticky: got %b want 1", timeout_err);
        end
        pulse_start();
        total++;
        if (timeout_err !== 1'b0 || load_ready !== 1'b1) begin
            bad++;
            $display("FAIL timeout_clear: got err %b load_ready %b want 0 1", timeout_err, load_ready);
        end
        do_load(2);
        do_req(1'b0);
        do_run(int'(TIMEOUT) - 1, 1'b0);
        do_drain(0);
    endtask

    task automatic test_reset_mid_load;
        int w0;
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            load_valid = 1'b1;
            load_data  = 8'(i + 8'hA0);
            tick();
        end
        #2;
        reset = 1'b1;
        #1;
        w0 = wr_total;
        total++;
        if (busy !== 1'b0 || load_ready !== 1'b0 || mem_wr_en !== 1'b0 || core_req !== 1'b0 ||
            out_valid !== 1'b0 || timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL midreset_flags: got busy %b lr %b wr %b req %b ov %b err %b want all 0",
                     busy, load_ready, mem_wr_en, core_req, out_valid, timeout_err);
        end
        total++;
        if (mem_addr !== 8'h00 || mem_wr_data !== 8'h00 || out_data !== 8'h00) begin
            bad++;
            $display("FAIL midreset_data: got addr %0h wdata %0h odata %0h want 0 0 0", mem_addr, mem_wr_data, out_data);
        end
        repeat (2) tick();
        reset = 1'b0;
        repeat (5) tick();
        load_valid = 1'b0;
        total++;
        if (wr_total != w0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL midreset_no_write: got writes %0d busy %b want 0 0", wr_total - w0, busy);
        end
    endtask

    task automatic test_random;
        for (int k = 0; k < 3; k++) begin
            preload_results(1'b0);
            pulse_start();
            do_load(2);
            do_req(1'($urandom_range(0, 1)));
            do_run($urandom_range(0, TIMEOUT - 1), 1'b1);
            do_drain(2);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_load_gaps();
        test_done_in_req();
        test_timeout();
        test_reset_mid_load();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/prog_host.md
PROG_HOST -- requirements
Module: prog_host

Interface
REQ-001 Parameter LOAD_BASE, default 0: first data-memory address written during load.
REQ-002 Parameter LOAD_LEN, default 64: bytes loaded, range 1..128.
REQ-003 Parameter RES_BASE, default 64: first data-memory address read back.
REQ-004 Parameter RES_LEN, default 64: bytes read back, range 1..128.
REQ-005 Parameter REQ_CYCLES, default 2: cycles core_req is held high, range 1..15.
REQ-006 Parameter TIMEOUT, default 4095: maximum run cycles before error, range 1..65535.
REQ-007 clk  in  1  sole clock; all state on rising edge.
REQ-008 reset  in  1  asynchronous, active-high reset.
REQ-009 start  in  1  one-cycle pulse; begins a session from IDLE.
REQ-010 load_valid  in  1  load byte offered.
REQ-011 load_data  in  8  load byte.
REQ-012 load_ready  out  1  block accepts load byte this cycle.
REQ-013 mem_wr_en  out  1  data-memory write strobe.
REQ-014 mem_addr  out  8  data-memory address.
REQ-015 mem_wr_data  out  8  data-memory write data.
REQ-016 mem_rd_data  in  8  data-memory read data, combinational from mem_addr.
REQ-017 core_req  out  1  processor reset/start request.
REQ-018 core_done  in  1  processor done level.
REQ-019 out_valid  out  1  result byte offered.
REQ-020 out_data  out  8  result byte.
REQ-021 out_ready  in  1  consumer accepts result byte.
REQ-022 busy  out  1  high in every state except IDLE.
REQ-023 timeout_err  out  1  sticky error flag, cleared on next accepted start.

Function
REQ-024 States SHALL be IDLE, LOAD, REQ, RUN, DRAIN, ERR; each occupies at least one cycle.
REQ-025 IDLE: start=1 -> LOAD, byte counter=0, timeout_err=0; start in any other state SHALL be ignored.
REQ-026 LOAD: load_ready=1; on load_valid&load_ready, mem_wr_en=1, mem_addr=LOAD_BASE+count (mod 256), mem_wr_data=load_data, count+1, same cycle.
REQ-027 LOAD: after the LOAD_LEN-th accepted byte -> REQ next cycle; load_valid=0 stalls with no write.
REQ-028 REQ: core_req=1 for exactly REQ_CYCLES cycles, then -> RUN; core_req=0 in all other states.
REQ-029 RUN: cycle counter from 0; core_done=1 -> DRAIN, count=0; core_done during REQ SHALL be ignored.
REQ-030 RUN: counter reaching TIMEOUT without core_done -> ERR, timeout_err=1; core_done in that same cycle takes priority (-> DRAIN).
REQ-031 DRAIN: mem_addr=RES_BASE+count (mod 256), out_valid=1, out_data=mem_rd_data; mem_addr held stable while out_valid&!out_ready.
REQ-032 DRAIN: on out_valid&out_ready count+1; after the RES_LEN-th transfer -> IDLE; mem_wr_en=0 throughout.
REQ-033 ERR: one cycle, -> IDLE; timeout_err stays 1.
REQ-034 mem_wr_en SHALL be 0 outside LOAD; load_ready and out_valid SHALL be 0 outside LOAD and DRAIN respectively.
REQ-035 Counters SHALL be wide enough never to wrap before their terminal value.

Reset
REQ-036 reset=1 SHALL immediately force IDLE, all counters 0, all outputs 0 (core_req=0, mem_wr_en=0, load_ready=0, out_valid=0, busy=0, timeout_err=0, mem_addr=0, mem_wr_data=0, out_data=0).
REQ-037 Reset mid-session SHALL abandon the session; no further memory writes until a new start after reset release.

Verification
REQ-038 Defaults, start, 64 bytes 0x00..0x3F back-to-back -> mem_wr_en 64 cycles, addr 0..63, then core_req high exactly 2 cycles.
REQ-039 load_valid toggled every other cycle -> writes only on valid cycles, addresses contiguous, no duplicates.
REQ-040 core_done asserted during REQ then low, asserted 10 cycles into RUN -> DRAIN entered only after the RUN assertion.
REQ-041 DRAIN with out_ready low 3 cycles per byte, mem holding addr value at 64..127 -> out_data 0x40..0x7F in order, each once.
REQ-042 TIMEOUT=20, core_done never -> ERR after 20 RUN cycles, timeout_err=1, IDLE; next start clears timeout_err.
REQ-043 reset pulsed at LOAD byte 10 -> outputs 0 asynchronously, busy=0; start ignored in RUN.
